// File: rtl/ssd1306_spi_receiver.sv
// ssd1306_spi_receiver: SSD1306 4-wire SPI panel model (SCLK/MOSI/DC/RES# in; byte, framebuffer write, display state out)
module ssd1306_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter logic [7:0] CONTRAST_RESET = 8'h7F
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  input  logic       i_DC,
  input  logic       i_RES_n,
  output logic [7:0] o_Byte,
  output logic       o_Byte_Valid,
  output logic       o_Byte_Is_Data,
  output logic       o_Fb_We,
  output logic [9:0] o_Fb_Addr,
  output logic [7:0] o_Fb_Data,
  output logic       o_Display_On,
  output logic [7:0] o_Contrast,
  output logic [1:0] o_Addr_Mode,
  output logic       o_Frame_Done
);
  typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;
  logic [3:0] sync_q [SYNC_STAGES];
  logic sclk_s, mosi_s, dc_s, res_n_s, sclk_d, rst, rise, done, we_n, fd_n, disp_n;
  logic [6:0] shift, arg1, arg_n, col, col_n, cs, cs_n, ce, ce_n, col_inc;
  logic [2:0] bit_cnt, page, page_n, ps, ps_n, pe, pe_n, page_inc;
  logic [7:0] rx, cmd, cmd_n, con_n;
  logic [1:0] mode_n;
  state_t state, state_n;
  assign {res_n_s, dc_s, mosi_s, sclk_s} = sync_q[SYNC_STAGES-1];
  assign rst = i_Reset | ~res_n_s;
  assign rise = sclk_s & ~sclk_d;
  assign done = rise && bit_cnt == 3'd7;
  assign rx = {shift, mosi_s};
  assign col_inc = col == ce ? cs : col + 7'd1;
  assign page_inc = page == pe ? ps : page + 3'd1;
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1000;
      sclk_d <= 1'b0;
    end else begin
      sync_q[0] <= {i_RES_n, i_DC, i_SPI_MOSI, i_SPI_Clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_d <= sclk_s;
    end
  end
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    arg_n = arg1;
    col_n = col;
    page_n = page;
    cs_n = cs;
    ce_n = ce;
    ps_n = ps;
    pe_n = pe;
    mode_n = o_Addr_Mode;
    con_n = o_Contrast;
    disp_n = o_Display_On;
    we_n = 1'b0;
    fd_n = 1'b0;
    if (done && dc_s) begin
      we_n = 1'b1;
      state_n = IDLE;
      fd_n = o_Addr_Mode != 2'd2 && col == ce && page == pe;
      col_n = (o_Addr_Mode != 2'd1 || page == pe) ? col_inc : col;
      page_n = ((o_Addr_Mode == 2'd0 && col == ce) || o_Addr_Mode == 2'd1) ? page_inc : page;
    end else if (done) begin
      case (state)
        IDLE: begin
          cmd_n = rx;
          if (rx[7:1] == 7'h57) disp_n = rx[0];
          if (rx inside {8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB}) state_n = ARG1;
          if (o_Addr_Mode == 2'd2) begin
            if (rx[7:3] == 5'b10110) page_n = rx[2:0];
            if (rx[7:4] == 4'h0) col_n[3:0] = rx[3:0];
            if (rx[7:3] == 5'b00010) col_n[6:4] = rx[2:0];
          end
        end
        ARG1: begin
          arg_n = rx[6:0];
          state_n = (cmd == 8'h21 || cmd == 8'h22) ? ARG2 : IDLE;
          if (cmd == 8'h20 && rx[1:0] != 2'd3) mode_n = rx[1:0];
          if (cmd == 8'h81) con_n = rx;
        end
        default: begin
          state_n = IDLE;
          if (cmd == 8'h21) begin
            cs_n = arg1;
            ce_n = rx[6:0];
            col_n = arg1;
          end
          if (cmd == 8'h22) begin
            ps_n = arg1[2:0];
            pe_n = rx[2:0];
            page_n = arg1[2:0];
          end
        end
      endcase
    end
  end
  always_ff @(posedge i_Clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      bit_cnt <= '0;
      cmd <= '0;
      arg1 <= '0;
      col <= '0;
      page <= '0;
      cs <= '0;
      ce <= 7'd127;
      ps <= '0;
      pe <= 3'd7;
      o_Addr_Mode <= 2'd2;
      o_Contrast <= CONTRAST_RESET;
      o_Display_On <= 1'b0;
      o_Byte <= '0;
      o_Byte_Valid <= 1'b0;
      o_Byte_Is_Data <= 1'b0;
      o_Fb_We <= 1'b0;
      o_Fb_Addr <= '0;
      o_Fb_Data <= '0;
      o_Frame_Done <= 1'b0;
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      arg1 <= arg_n;
      col <= col_n;
      page <= page_n;
      cs <= cs_n;
      ce <= ce_n;
      ps <= ps_n;
      pe <= pe_n;
      o_Addr_Mode <= mode_n;
      o_Contrast <= con_n;
      o_Display_On <= disp_n;
      if (rise) begin
        shift <= rx[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
      o_Byte_Valid <= done;
      if (done) begin
        o_Byte <= rx;
        o_Byte_Is_Data <= dc_s;
      end
      o_Fb_We <= we_n;
      if (we_n) begin
        o_Fb_Addr <= {page, col};
        o_Fb_Data <= rx;
      end
      o_Frame_Done <= fd_n;
    end
  end
endmodule
